// File: rtl/lsu_ctrl_if.sv
// Request/response and RAM-port bundle for lsu_ctrl.
// The slave modport is the controller; the master modport is the requester plus RAM.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic              ready_o;
  logic              resp_valid_o;
  logic [31:0]       rdata_o;
  logic              err_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_waddr_o;
  logic [31:0]       ram_wdata_o;
  logic              ram_re_o;
  logic [ADDR_W-1:0] ram_raddr_o;
  logic [31:0]       ram_rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, size_i, unsigned_i, ram_rdata_i,
    output ready_o, resp_valid_o, rdata_o, err_o,
    output ram_we_o, ram_waddr_o, ram_wdata_o, ram_re_o, ram_raddr_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, size_i, unsigned_i, ram_rdata_i,
    input  ready_o, resp_valid_o, rdata_o, err_o,
    input  ram_we_o, ram_waddr_o, ram_wdata_o, ram_re_o, ram_raddr_o
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-request load/store controller: sub-word loads with extension, sub-word stores via read-modify-write.
// Define LSU_MISALIGN_CHECK_EN to reject illegal sizes and misaligned half/word accesses with err_o.
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       rst,
  lsu_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LD     = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] WR     = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]        state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              err_q;
  logic [31:0]       word_q;   // store data at acceptance, merged write word after RMW_RD
  logic [31:0]       rdata_q;

  logic              accept;
  logic              req_err;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] ram_addr;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: r = {{24{b[7] & ~u}}, b};
      SZ_HALF: r = {{16{h[15] & ~u}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                        input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (sz)
      SZ_BYTE: r[{a, 3'b000} +: 8]     = d[7:0];
      SZ_HALF: r[{a[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // Size 11 is folded into word when misalignment checking is off.
  always_comb begin
    req_size = bus.size_i;
    req_err  = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    req_err = (bus.size_i == 2'b11) ||
              ((bus.size_i == SZ_HALF) && bus.addr_i[0]) ||
              ((bus.size_i == SZ_WORD) && (bus.addr_i[1:0] != 2'b00));
`else
    if (bus.size_i == 2'b11) begin
      req_size = SZ_WORD;
    end
`endif
  end

  assign bus.ready_o = (state_q == IDLE) && !rst;
  assign accept      = bus.req_i && bus.ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                state_d = RESP;
          else if (!bus.we_i)         state_d = LD;
          else if (req_size == SZ_WORD) state_d = WR;
          else                        state_d = RMW_RD;
        end
      end
      LD:      state_d = RESP;
      RMW_RD:  state_d = WR;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q   <= bus.we_i;
        addr_q <= bus.addr_i;
        size_q <= req_size;
        uns_q  <= bus.unsigned_i;
        err_q  <= req_err;
        word_q <= bus.wdata_i;
      end
      if (state_q == LD) begin
        rdata_q <= extract(bus.ram_rdata_i, addr_q[1:0], size_q, uns_q);
      end
      if (state_q == RMW_RD) begin
        word_q <= merge(bus.ram_rdata_i, addr_q[1:0], size_q, word_q);
      end
    end
  end

  assign ram_addr = {addr_q[ADDR_W-1:2], 2'b00};

  assign bus.ram_re_o    = (state_q == LD) || (state_q == RMW_RD);
  assign bus.ram_raddr_o = bus.ram_re_o ? ram_addr : '0;
  assign bus.ram_we_o    = (state_q == WR);
  assign bus.ram_waddr_o = bus.ram_we_o ? ram_addr : '0;
  assign bus.ram_wdata_o = bus.ram_we_o ? word_q : 32'd0;

  assign bus.resp_valid_o = (state_q == RESP);
  // Stores and rejected requests report zero data; otherwise the last load result persists.
  assign bus.rdata_o = (bus.resp_valid_o && (we_q || err_q)) ? 32'd0 : rdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign bus.err_o = bus.resp_valid_o && err_q;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomised bench for lsu_ctrl: a transaction-level model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(32)) bus ();
  lsu_ctrl #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 'h40) return 32'h8899AABB;
    return 32'(i) * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // RAM seen by the DUT: combinational read, write on the clock edge
  logic [31:0] ram [0:255];
  logic        ram_inited = 1'b0;
  assign bus.ram_rdata_i = ram[bus.ram_raddr_o[9:2]];
  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_inited <= 1'b1;
    end else if (bus.ram_we_o) begin
      ram[bus.ram_waddr_o[9:2]] <= bus.ram_wdata_o;
    end
  end

  // Transaction-level reference model
  logic [31:0] model_mem [0:255];
  bit          busy;
  int          off, lat;
  bit          m_we, m_err, m_has_re;
  logic [31:0] m_aln, m_res, m_ww, last_load;

  task automatic model_accept();
    logic [31:0] a, w, d, v, mask;
    logic [1:0]  sz;
    int          sh;
    a = bus.addr_i; d = bus.wdata_i; sz = bus.size_i;
    m_err = 0;
`ifdef LSU_MISALIGN_CHECK_EN
    m_err = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
`else
    if (sz == 3) sz = 2;
`endif
    w  = model_mem[a[9:2]];
    sh = (sz == 0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    m_we  = bus.we_i;
    m_aln = a & 32'hFFFF_FFFC;
    if (sz == 2) m_res = w;
    else if (sz == 0) begin
      v = (w >> sh) & 32'hFF;
      if (!bus.unsigned_i && v[7]) v = v | 32'hFFFF_FF00;
      m_res = v;
    end else begin
      v = (w >> sh) & 32'hFFFF;
      if (!bus.unsigned_i && v[15]) v = v | 32'hFFFF_0000;
      m_res = v;
    end
    if (sz == 2) m_ww = d;
    else begin
      mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << sh;
      m_ww = (w & ~mask) | ((d << sh) & mask);
    end
    lat      = m_err ? 1 : (!m_we ? 2 : (sz == 2 ? 2 : 3));
    m_has_re = !m_err && (!m_we || sz != 2);
    busy = 1; off = 1;
  endtask

  initial begin
    bit          e_resp, e_re, e_we;
    logic [31:0] e_rdata;
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    busy = 0; last_load = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        e_resp = 0; e_re = 0; e_we = 0; e_rdata = 0;
      end else begin
        e_resp  = busy && off == lat;
        e_re    = busy && m_has_re && off == 1;
        e_we    = busy && m_we && !m_err && off == lat - 1;
        e_rdata = e_resp ? ((m_we || m_err) ? 32'd0 : m_res) : last_load;
      end
      chk("ready_o",      bus.ready_o,      32'(!rst && !busy));
      chk("resp_valid_o", bus.resp_valid_o, 32'(e_resp));
      chk("err_o",        bus.err_o,        32'(e_resp && m_err));
      chk("rdata_o",      bus.rdata_o,      e_rdata);
      chk("ram_re_o",     bus.ram_re_o,     32'(e_re));
      chk("ram_raddr_o",  bus.ram_raddr_o,  e_re ? m_aln : 32'd0);
      chk("ram_we_o",     bus.ram_we_o,     32'(e_we));
      chk("ram_waddr_o",  bus.ram_waddr_o,  e_we ? m_aln : 32'd0);
      chk("ram_wdata_o",  bus.ram_wdata_o,  e_we ? m_ww : 32'd0);
      if (rst) begin
        busy = 0; last_load = 0;
      end else if (busy) begin
        if (e_we) model_mem[m_aln[9:2]] = m_ww;
        if (off == lat) begin
          busy = 0;
          if (!m_we && !m_err) last_load = m_res;
        end else off++;
      end else if (bus.req_i) begin
        model_accept();
      end
    end
  end

  task automatic randomize_fields();
    bus.we_i       = 1'($urandom);
    bus.addr_i     = 32'($urandom_range(0, 1023));
    bus.wdata_i    = $urandom;
    bus.size_i     = 2'($urandom);
    bus.unsigned_i = 1'($urandom);
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u,
                        output int re_c, output int we_c, output int rs_c,
                        output logic [31:0] wa, output logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    int n;
    re_c = -1; we_c = -1; rs_c = -1; wa = 0; wd = 0; rd = 0; er = 0;
    @(posedge clk); #1;
    bus.req_i = 1; bus.we_i = w; bus.addr_i = a; bus.wdata_i = d;
    bus.size_i = sz; bus.unsigned_i = u;
    n = 0;
    @(negedge clk);
    while (!bus.ready_o && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", bus.ready_o, 1);
    if (!bus.ready_o) begin bus.req_i = 0; return; end
    @(posedge clk); #1;
    bus.req_i = 0;
    randomize_fields();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus.ram_re_o) re_c = k;
      if (bus.ram_we_o) begin we_c = k; wa = bus.ram_waddr_o; wd = bus.ram_wdata_o; end
      if (bus.resp_valid_o) begin rs_c = k; rd = bus.rdata_o; er = bus.err_o; break; end
    end
    chk("resp_seen", 32'(rs_c > 0), 1);
  endtask

  initial begin
    int          re_c, we_c, rs_c, cnt;
    logic [31:0] wa, wd, rd;
    logic        er;
    bus.req_i = 0; bus.we_i = 0; bus.addr_i = 0; bus.wdata_i = 0;
    bus.size_i = 0; bus.unsigned_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", bus.ready_o, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("ready_after_reset", bus.ready_o, 1);

    // Byte load signed/unsigned from 0x102 over 0x8899AABB
    do_req(0, 32'h102, 0, 2'b00, 0, re_c, we_c, rs_c, wa, wd, rd, er);
    chk("ldb_re_cycle", re_c, 1);
    chk("ldb_resp_cycle", rs_c, 2);
    chk("ldb_signed", rd, 32'hFFFF_FF99);
    do_req(0, 32'h102, 0, 2'b00, 1, re_c, we_c, rs_c, wa, wd, rd, er);
    chk("ldb_unsigned", rd, 32'h0000_0099);

    // Half store read-modify-write
    do_req(1, 32'h102, 32'h1234, 2'b01, 0, re_c, we_c, rs_c, wa, wd, rd, er);
    chk("sth_re_cycle", re_c, 1);
    chk("sth_we_cycle", we_c, 2);
    chk("sth_waddr", wa, 32'h100);
    chk("sth_wdata", wd, 32'h1234_AABB);
    chk("sth_resp_cycle", rs_c, 3);
    chk("sth_rdata_zero", rd, 0);
    do_req(0, 32'h100, 0, 2'b10, 0, re_c, we_c, rs_c, wa, wd, rd, er);
    chk("ldw_after_sth", rd, 32'h1234_AABB);

    // Word store then load
    do_req(1, 32'h200, 32'hDEAD_BEEF, 2'b10, 0, re_c, we_c, rs_c, wa, wd, rd, er);
    chk("stw_we_cycle", we_c, 1);
    chk("stw_re_none", re_c, -1);
    chk("stw_resp_cycle", rs_c, 2);
    do_req(0, 32'h200, 0, 2'b10, 0, re_c, we_c, rs_c, wa, wd, rd, er);
    chk("ldw_data", rd, 32'hDEAD_BEEF);

    // Misaligned word load
    do_req(0, 32'h201, 0, 2'b10, 0, re_c, we_c, rs_c, wa, wd, rd, er);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_resp_cycle", rs_c, 1);
    chk("mis_err", er, 1);
    chk("mis_no_read", re_c, -1);
`else
    chk("mis_resp_cycle", rs_c, 2);
    chk("mis_err", er, 0);
    chk("mis_data", rd, 32'hDEAD_BEEF);
`endif

    // Reset while a byte store sits in RMW_RD
    @(posedge clk); #1;
    bus.req_i = 1; bus.we_i = 1; bus.addr_i = 32'h105; bus.wdata_i = 32'h5A;
    bus.size_i = 2'b00; bus.unsigned_i = 0;
    @(negedge clk);
    chk("rst_case_accept", bus.ready_o, 1);
    @(posedge clk); #1 bus.req_i = 0; rst = 1;
    @(negedge clk);
    chk("rst_ready_low", bus.ready_o, 0);
    chk("rst_re_low", bus.ram_re_o, 0);
    chk("rst_rdata_zero", bus.rdata_o, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_ready_release", bus.ready_o, 1);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.ram_we_o || bus.resp_valid_o) cnt++;
      @(negedge clk);
    end
    chk("rst_abort_no_activity", cnt, 0);

    // req_i held high back-to-back
    @(posedge clk); #1 bus.req_i = 1;
    for (int k = 0; k < 300; k++) begin
      randomize_fields();
      @(posedge clk); #1;
    end
    bus.req_i = 0;

    // Random traffic with occasional resets
    for (int k = 0; k < 4000; k++) begin
      bus.req_i = ($urandom_range(0, 9) < 6);
      randomize_fields();
      rst = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 0; bus.req_i = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
